// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file's single write port: in-order ALU results
// take priority over buffered long-latency results, with a pending-destination scoreboard.
module wb_arbiter #(
    parameter int DW    = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [DW-1:0]            alu_wd,
    input  logic                     lu_issue,
    input  logic [4:0]               lu_issue_rd,
    input  logic                     lu_valid,
    input  logic [4:0]               lu_rd,
    input  logic [DW-1:0]            lu_wd,
    output logic                     lu_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [DW-1:0]            rf_wd,
    output logic [NREG-1:0]          busy_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]      rdMem_q [DEPTH];
    logic [DW-1:0]   wdMem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW:0]     count_q, count_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            rfWe_q, rfWe_d;
    logic [4:0]      rfRd_q, rfRd_d;
    logic [DW-1:0]   rfWd_q, rfWd_d;

    logic            push, pop, aluSel;
    logic [4:0]      headRd;
    logic [DW-1:0]   headWd;
    logic [NREG-1:0] setMask, clrMask;

    assign headRd = rdMem_q[rdPtr_q];
    assign headWd = wdMem_q[rdPtr_q];

    // The ALU has no backpressure, so it wins the port; an rd=0 result is discarded
    // and the slot falls through to the FIFO head.
    always_comb begin
        lu_ready = (count_q < (AW+1)'(DEPTH));
        push     = lu_valid && lu_ready;
        aluSel   = alu_valid && (alu_rd != 5'd0);
        pop      = !aluSel && (count_q != '0);

        wrPtr_d  = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d  = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        rfWe_d   = 1'b0;
        rfRd_d   = rfRd_q;
        rfWd_d   = rfWd_q;
        if (aluSel) begin
            rfWe_d = 1'b1;
            rfRd_d = alu_rd;
            rfWd_d = alu_wd;
        end else if (pop) begin
            rfWe_d = (headRd != 5'd0);
            rfRd_d = headRd;
            rfWd_d = headWd;
        end
    end

    // Set is applied after clear so an issue in the same cycle as a pop keeps the bit busy.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (lu_issue && (lu_issue_rd != 5'd0))
            setMask = NREG'(1) << lu_issue_rd;
        if (pop && (headRd != 5'd0))
            clrMask = NREG'(1) << headRd;
        busy_d    = (busy_q & ~clrMask) | setMask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            busy_q  <= '0;
            rfWe_q  <= 1'b0;
            rfRd_q  <= '0;
            rfWd_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            rfWe_q  <= rfWe_d;
            rfRd_q  <= rfRd_d;
            rfWd_q  <= rfWd_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            rdMem_q[wrPtr_q] <= lu_rd;
            wdMem_q[wrPtr_q] <= lu_wd;
        end
    end

    assign rf_we      = rfWe_q;
    assign rf_rd      = rfRd_q;
    assign rf_wd      = rfWd_q;
    assign busy_mask  = busy_q;
    assign fifo_count = count_q;

    // Decode must stall on busy registers; a register being freed this cycle may be reissued.
    assert property (@(posedge clk) disable iff (reset)
        !(lu_issue && (lu_issue_rd != 5'd0) && busy_q[lu_issue_rd] &&
          !(pop && (headRd == lu_issue_rd))))
        else $error("wb_arbiter: long-latency issue to busy register x%0d", lu_issue_rd);

    assert property (@(posedge clk) disable iff (reset)
        !(aluSel && busy_q[alu_rd]))
        else $error("wb_arbiter: ALU write to busy register x%0d", alu_rd);

endmodule
